// File: rtl/operador_pipe_if.sv
// Handshake bus of the two-stage operator pipeline: instruction/operand input side and result output side.
// flag_c/flag_z exist only when OPERADOR_FLAGS_EN is defined.
interface operador_pipe_if #(
    parameter int WIDTH = 4
);
    logic [7:0]       instr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dato_mux;
    logic             out_valid;
    logic             out_ready;
`ifdef OPERADOR_FLAGS_EN
    logic             flag_c;
    logic             flag_z;
`endif

    modport master (
        output instr, A, B, in_valid, out_ready,
`ifdef OPERADOR_FLAGS_EN
        input  flag_c, flag_z,
`endif
        input  in_ready, dato_mux, out_valid
    );

    modport slave (
        input  instr, A, B, in_valid, out_ready,
`ifdef OPERADOR_FLAGS_EN
        output flag_c, flag_z,
`endif
        output in_ready, dato_mux, out_valid
    );
endinterface

// File: rtl/operador_pipe.sv
// Two-stage operator pipeline: S1 captures opcode/operands, S2 computes and registers the result.
// Optional carry/zero flags are compiled in with the OPERADOR_FLAGS_EN macro.
module operador_pipe #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic           clk,
    input  logic           rst,
    operador_pipe_if.slave bus
);

    logic             advance_s;
    logic [OPW-1:0]   opcode_s;
    logic             unused_instr_s;

    logic             s1_valid_q, s1_valid_d;
    logic [OPW-1:0]   s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;

    logic [WIDTH-1:0] res_s;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dato_q,      dato_d;

    function automatic logic [WIDTH-1:0] alu_result(
        input logic [OPW-1:0]   op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = ~a;
            3'd2:    r = {a[WIDTH-2:0], 1'b0};
            3'd3:    r = {1'b0, a[WIDTH-1:1]};
            3'd4:    r = {{(WIDTH-1){1'b0}}, (a == b)};
            3'd5:    r = {{(WIDTH-1){1'b0}}, (a > b)};
            3'd6:    r = {a[WIDTH-1], a[WIDTH-1:1]};
            3'd7:    r = a & b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign opcode_s       = bus.instr[7 -: OPW];
    assign unused_instr_s = ^bus.instr[7-OPW:0];
    assign advance_s      = !out_valid_q || bus.out_ready;
    assign bus.in_ready   = advance_s;

    // S1 next state: valid tracks in_valid on every advance, operands load only on a transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (advance_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d = opcode_s;
                s1_a_d  = bus.A;
                s1_b_d  = bus.B;
            end else begin
                s1_op_d = s1_op_q;
                s1_a_d  = s1_a_q;
                s1_b_d  = s1_b_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= {OPW{1'b0}};
            s1_a_q     <= {WIDTH{1'b0}};
            s1_b_q     <= {WIDTH{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
        end
    end

    // Combinational result of the operation held in S1.
    always_comb begin
        res_s = alu_result(s1_op_q, s1_a_q, s1_b_q);
    end

    // S2 next state: reload from S1 whenever the pipe advances, otherwise hold for the stalled consumer.
    always_comb begin
        out_valid_d = out_valid_q;
        dato_d      = dato_q;
        if (advance_s) begin
            out_valid_d = s1_valid_q;
            dato_d      = res_s;
        end else begin
            out_valid_d = out_valid_q;
            dato_d      = dato_q;
        end
    end

    // S2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dato_q      <= {WIDTH{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            dato_q      <= dato_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dato_mux  = dato_q;

`ifdef OPERADOR_FLAGS_EN
    logic carry_s;
    logic flag_c_q, flag_c_d;
    logic flag_z_q, flag_z_d;

    // Unsigned add overflows exactly when the truncated sum wraps below an operand.
    function automatic logic alu_carry(
        input logic [OPW-1:0]   op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic c;
        case (op)
            3'd0:    c = ((a + b) < a);
            3'd2:    c = a[WIDTH-1];
            3'd3:    c = a[0];
            3'd6:    c = a[0];
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Carry of the operation held in S1.
    always_comb begin
        carry_s = alu_carry(s1_op_q, s1_a_q, s1_b_q);
    end

    // Flag next state follows the same advance/hold rule as the result.
    always_comb begin
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        if (advance_s) begin
            flag_c_d = carry_s;
            flag_z_d = (res_s == {WIDTH{1'b0}});
        end else begin
            flag_c_d = flag_c_q;
            flag_z_d = flag_z_q;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign bus.flag_c = flag_c_q;
    assign bus.flag_z = flag_z_q;
`endif

endmodule

// File: tb/tb_operador_pipe.sv
// Directed bench for operador_pipe: streaming vector table plus stall, reset and WIDTH=8 sequences.
module tb_operador_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    operador_pipe_if #(.WIDTH(4)) bus4 ();
    operador_pipe_if #(.WIDTH(8)) bus8 ();

    operador_pipe #(.WIDTH(4), .OPW(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    operador_pipe #(.WIDTH(8), .OPW(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       z;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic c, input logic z);
`ifdef OPERADOR_FLAGS_EN
        chk({name, "_c"}, {31'd0, bus4.flag_c}, {31'd0, c});
        chk({name, "_z"}, {31'd0, bus4.flag_z}, {31'd0, z});
`else
        if (c === 1'bx || z === 1'bx) $display("flag expectation undefined for %s", name);
`endif
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bus4.in_valid = v;
        bus4.instr    = {op, 5'b10110};
        bus4.A        = a;
        bus4.B        = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{3'd0, 4'd9,    4'd8,    4'd1,    1'b1, 1'b0};
        vec[1]  = '{3'd2, 4'b1001, 4'd0,    4'b0010, 1'b1, 1'b0};
        vec[2]  = '{3'd3, 4'b1001, 4'd0,    4'b0100, 1'b1, 1'b0};
        vec[3]  = '{3'd6, 4'b1001, 4'd0,    4'b1100, 1'b1, 1'b0};
        vec[4]  = '{3'd4, 4'd5,    4'd5,    4'd1,    1'b0, 1'b0};
        vec[5]  = '{3'd5, 4'd3,    4'd7,    4'd0,    1'b0, 1'b1};
        vec[6]  = '{3'd1, 4'b1010, 4'd3,    4'b0101, 1'b0, 1'b0};
        vec[7]  = '{3'd7, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0};
        vec[8]  = '{3'd0, 4'd3,    4'd4,    4'd7,    1'b0, 1'b0};
        vec[9]  = '{3'd1, 4'hF,    4'd0,    4'd0,    1'b0, 1'b1};
        vec[10] = '{3'd5, 4'd9,    4'd2,    4'd1,    1'b0, 1'b0};
        vec[11] = '{3'd2, 4'b0111, 4'd0,    4'b1110, 1'b0, 1'b0};
        vec[12] = '{3'd3, 4'b0110, 4'd0,    4'b0011, 1'b0, 1'b0};
        vec[13] = '{3'd6, 4'b0110, 4'd0,    4'b0011, 1'b0, 1'b0};
        vec[14] = '{3'd0, 4'd8,    4'd8,    4'd0,    1'b1, 1'b1};
        vec[15] = '{3'd7, 4'b0101, 4'b1010, 4'd0,    1'b0, 1'b1};

        // Reset: in_valid held high must not be accepted while rst=1.
        bus4.out_ready = 1'b1;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.instr     = 8'h00;
        bus8.A         = 8'h00;
        bus8.B         = 8'h00;
        drive(1'b1, 3'd1, 4'd0, 4'd0);
        #2;
        chk("rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 4'd0);
        chk("post_rst_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        chk("post_rst_dato", {28'd0, bus4.dato_mux}, 32'd0);
        chk_flags("post_rst", 1'b0, 1'b0);
        step();
        step();
        chk("no_accept_in_rst", {31'd0, bus4.out_valid}, 32'd0);

        // Streaming table: one op per cycle, result two edges after being presented.
        drive(1'b1, vec[0].op, vec[0].a, vec[0].b);
        for (int e = 0; e <= NV; e++) begin
            step();
            if (e == 0) begin
                chk("latency_first_edge", {31'd0, bus4.out_valid}, 32'd0);
            end else begin
                chk($sformatf("vec%0d_valid", e - 1), {31'd0, bus4.out_valid}, 32'd1);
                chk($sformatf("vec%0d_res", e - 1), {28'd0, bus4.dato_mux}, {28'd0, vec[e-1].res});
                chk_flags($sformatf("vec%0d", e - 1), vec[e-1].c, vec[e-1].z);
            end
            if (e + 1 < NV) drive(1'b1, vec[e+1].op, vec[e+1].a, vec[e+1].b);
            else            drive(1'b0, 3'd0, 4'd0, 4'd0);
        end
        step();
        chk("drain_valid", {31'd0, bus4.out_valid}, 32'd0);

        // Stall with two ops in flight: A = 2+3, B = F&6; a third op must not be taken.
        drive(1'b1, 3'd0, 4'd2, 4'd3);
        step();
        drive(1'b1, 3'd7, 4'hF, 4'd6);
        step();
        chk("stall_first_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("stall_first_dato", {28'd0, bus4.dato_mux}, 32'd5);
        bus4.out_ready = 1'b0;
        drive(1'b1, 3'd0, 4'd1, 4'd1);
        #1;
        chk("stall_in_ready", {31'd0, bus4.in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_in_ready", k), {31'd0, bus4.in_ready}, 32'd0);
            chk($sformatf("stall%0d_valid", k), {31'd0, bus4.out_valid}, 32'd1);
            chk($sformatf("stall%0d_dato", k), {28'd0, bus4.dato_mux}, 32'd5);
        end
        bus4.out_ready = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 4'd0);
        #1;
        chk("unstall_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        step();
        chk("unstall_second_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("unstall_second_dato", {28'd0, bus4.dato_mux}, 32'd6);
        step();
        chk("unstall_no_third", {31'd0, bus4.out_valid}, 32'd0);

        // Reset during a stall: out_valid drops at once and nothing is replayed.
        drive(1'b1, 3'd1, 4'd0, 4'd0);
        step();
        drive(1'b1, 3'd0, 4'd1, 4'd1);
        step();
        chk("rstall_valid", {31'd0, bus4.out_valid}, 32'd1);
        chk("rstall_dato", {28'd0, bus4.dato_mux}, 32'd15);
        bus4.out_ready = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 4'd0);
        step();
        chk("rstall_hold", {28'd0, bus4.dato_mux}, 32'd15);
        rst = 1'b1;
        #1;
        chk("rstall_async_valid", {31'd0, bus4.out_valid}, 32'd0);
        chk("rstall_async_dato", {28'd0, bus4.dato_mux}, 32'd0);
        chk("rstall_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        chk_flags("rstall", 1'b0, 1'b0);
        drive(1'b1, 3'd0, 4'd7, 4'd7);
        step();
        rst = 1'b0;
        bus4.out_ready = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 4'd0);
        chk("rstall_release_in_ready", {31'd0, bus4.in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rstall_no_replay%0d", k), {31'd0, bus4.out_valid}, 32'd0);
        end

        // WIDTH=8 wrap: FF + 01.
        bus8.instr    = {3'd0, 5'b01011};
        bus8.A        = 8'hFF;
        bus8.B        = 8'h01;
        bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        step();
        chk("w8_valid", {31'd0, bus8.out_valid}, 32'd1);
        chk("w8_dato", {24'd0, bus8.dato_mux}, 32'd0);
`ifdef OPERADOR_FLAGS_EN
        chk("w8_c", {31'd0, bus8.flag_c}, 32'd1);
        chk("w8_z", {31'd0, bus8.flag_z}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
